// File: rtl/regfile_writeback_if.sv
// Write-back bundle between execute/memory, decode and the register file.
// Carries the issue/scoreboard query lines, the ALU result, the long-latency
// valid/ready result channel and the register-file write port.
interface regfile_writeback_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic              iss_valid;
  logic              iss_long;
  logic [ADDR_W-1:0] iss_rd;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] q_rs1;
  logic [ADDR_W-1:0] q_rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_regwrite;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  lq_count;

  // Write-back controller side
  modport slave (
    input  iss_valid, iss_long, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  q_rs1, q_rs2,
    output ld_ready, rs1_busy, rs2_busy,
    output wb_rd, wb_regwrite, wb_data, lq_count
  );

  // Pipeline / decode / register-file side
  modport master (
    output iss_valid, iss_long, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output q_rs1, q_rs2,
    input  ld_ready, rs1_busy, rs2_busy,
    input  wb_rd, wb_regwrite, wb_data, lq_count
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-side controller. Merges the unstallable ALU result
// with long-latency results buffered in a small FIFO, drives a registered
// rd/regwrite/datain write port, and tracks per-register busy bits for
// in-flight long-latency ops so decode can stall on RAW hazards.
module regfile_writeback #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_writeback_if.slave   bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LQ_DEPTH);

  // FIFO storage (data only, never reset) and control
  logic [ADDR_W-1:0] lq_rd_q   [LQ_DEPTH];
  logic [ADDR_W-1:0] lq_rd_d   [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Write-back output stage
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_long_q, wb_long_d;

  // Busy scoreboard, bit 0 kept at zero
  logic [NREG-1:0]   busy_q, busy_d;

  logic ld_ready;
  logic push;
  logic pop;

  // Ready depends on registered occupancy only, so the drain never reaches it
  assign ld_ready = (count_q != FULL);
  assign push     = bus.ld_valid && ld_ready;
  // ALU has strict priority; an entry pushed this cycle is not yet counted
  assign pop      = !bus.alu_valid && (count_q != '0);

  // FIFO next-state: write at tail, advance head on pop, track occupancy
  always_comb begin
    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      lq_rd_d[wr_ptr_q]   = bus.ld_rd;
      lq_data_d[wr_ptr_q] = bus.ld_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output stage select: ALU first, else FIFO head, else hold rd/data
  always_comb begin
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_regwrite_d = 1'b0;
    wb_long_d     = 1'b0;
    if (bus.alu_valid) begin
      wb_rd_d       = bus.alu_rd;
      wb_data_d     = bus.alu_data;
      wb_regwrite_d = (bus.alu_rd != '0);
    end else if (pop) begin
      wb_rd_d       = lq_rd_q[rd_ptr_q];
      wb_data_d     = lq_data_q[rd_ptr_q];
      wb_regwrite_d = (lq_rd_q[rd_ptr_q] != '0);
      wb_long_d     = 1'b1;
    end
  end

  // Scoreboard: clear on committed long write, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_regwrite_q && wb_long_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_long && (bus.iss_rd != '0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // FIFO storage capture
  always_ff @(posedge clk) begin
    lq_rd_q   <= lq_rd_d;
    lq_data_q <= lq_data_d;
  end

  // Control and output registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_regwrite_q <= 1'b0;
      wb_long_q     <= 1'b0;
      busy_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_long_q     <= wb_long_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.lq_count    = count_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.rs1_busy    = busy_q[bus.q_rs1];
  assign bus.rs2_busy    = busy_q[bus.q_rs2];

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a vector table walked in a loop, hand-written
// sequences for back-pressure, set/clear collision and reset mid-operation,
// and a cycle-level reference model with a queue of pending long results.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_writeback_if #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(DEPTH)) bus ();

  regfile_writeback #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        lq_m[$];
  ent_t        e_m;
  int          sz0;
  logic        m_we   = 1'b0;
  logic        m_long = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;
  logic [31:0] nb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lq_m.delete();
      m_we = 1'b0; m_long = 1'b0; m_rd = '0; m_data = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (m_we && m_long) nb[m_rd] = 1'b0;
      if (bus.iss_valid && bus.iss_long && bus.iss_rd != 0) nb[bus.iss_rd] = 1'b1;
      m_busy = nb;
      sz0 = lq_m.size();
      if (bus.alu_valid) begin
        m_rd = bus.alu_rd; m_data = bus.alu_data; m_we = (bus.alu_rd != 0); m_long = 1'b0;
      end else if (sz0 > 0) begin
        e_m = lq_m.pop_front();
        m_rd = e_m.rd; m_data = e_m.data; m_we = (e_m.rd != 0); m_long = 1'b1;
      end else begin
        m_we = 1'b0; m_long = 1'b0;
      end
      if (bus.ld_valid && sz0 < DEPTH) lq_m.push_back('{rd: bus.ld_rd, data: bus.ld_data});
    end
  end

  // Every cycle out of reset, compare the DUT with the model
  always @(negedge clk) begin
    if (reset) begin
      chk("mdl_we",    32'(bus.wb_regwrite), 32'(m_we));
      chk("mdl_rd",    32'(bus.wb_rd),       32'(m_rd));
      chk("mdl_data",  bus.wb_data,          m_data);
      chk("mdl_cnt",   32'(bus.lq_count),    32'(lq_m.size()));
      chk("mdl_ready", 32'(bus.ld_ready),    32'(lq_m.size() != DEPTH));
      chk("mdl_rs1b",  32'(bus.rs1_busy),    32'(m_busy[bus.q_rs1]));
      chk("mdl_rs2b",  32'(bus.rs2_busy),    32'(m_busy[bus.q_rs2]));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        alu_v; logic [4:0] alu_rd; logic [31:0] alu_data;
    logic        ld_v;  logic [4:0] ld_rd;  logic [31:0] ld_data;
    logic        iss_l; logic [4:0] iss_rd; logic [4:0]  q1;
    logic        e_we;  logic [4:0] e_rd;   logic [31:0] e_data;
    int          e_cnt; logic e_b1; logic e_b2;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
    input logic il, input logic [4:0] ir, input logic [4:0] q1,
    input logic we, input logic [4:0] rd, input logic [31:0] dt,
    input int cnt, input logic b1, input logic b2);
    vec_t v;
    v.alu_v = av; v.alu_rd = ar; v.alu_data = ad;
    v.ld_v = lv; v.ld_rd = lr; v.ld_data = ldd;
    v.iss_l = il; v.iss_rd = ir; v.q1 = q1;
    v.e_we = we; v.e_rd = rd; v.e_data = dt; v.e_cnt = cnt; v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  task automatic idle();
    bus.iss_valid = 0; bus.iss_long = 0; bus.iss_rd = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    bus.q_rs1 = 0; bus.q_rs2 = 9;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb_exp(input string nm, input logic we, input logic [4:0] rd,
                        input logic [31:0] dt, input int cnt);
    chk({nm, "_we"},  32'(bus.wb_regwrite), 32'(we));
    chk({nm, "_rd"},  32'(bus.wb_rd), 32'(rd));
    chk({nm, "_dat"}, bus.wb_data, dt);
    chk({nm, "_cnt"}, 32'(bus.lq_count), 32'(cnt));
  endtask

  int  pushed;
  int  guard;
  logic hs;

  initial begin
    idle();
    // Expected outputs are what the write port shows after each row's edge
    tbl[0]  = mk(1,7,32'hDEADBEEF, 0,0,0,        0,0,7, 1,7,32'hDEADBEEF, 0,0,0);
    tbl[1]  = mk(0,0,0,            0,0,0,        0,0,7, 0,7,32'hDEADBEEF, 0,0,0);
    tbl[2]  = mk(0,0,0,            0,0,0,        1,9,9, 0,7,32'hDEADBEEF, 0,1,1);
    tbl[3]  = mk(0,0,0,            1,9,32'h1234, 0,0,9, 0,7,32'hDEADBEEF, 1,1,1);
    tbl[4]  = mk(0,0,0,            0,0,0,        0,0,9, 1,9,32'h1234,     0,1,1);
    tbl[5]  = mk(0,0,0,            0,0,0,        0,0,9, 0,9,32'h1234,     0,0,0);
    tbl[6]  = mk(1,0,32'h55,       0,0,0,        0,0,0, 0,0,32'h55,       0,0,0);
    tbl[7]  = mk(0,0,0,            1,0,32'h66,   1,0,0, 0,0,32'h55,       1,0,0);
    tbl[8]  = mk(0,0,0,            0,0,0,        0,0,0, 0,0,32'h66,       0,0,0);
    tbl[9]  = mk(1,12,32'hA5A5A5A5,1,13,32'h77,  0,0,0, 1,12,32'hA5A5A5A5,1,0,0);
    tbl[10] = mk(1,14,32'h11111111,0,0,0,        0,0,0, 1,14,32'h11111111,1,0,0);
    tbl[11] = mk(0,0,0,            0,0,0,        0,0,0, 1,13,32'h77,      0,0,0);
    tbl[12] = mk(0,0,0,            0,0,0,        0,0,0, 0,13,32'h77,      0,0,0);

    // Reset state
    #2;
    chk("rst_we",  32'(bus.wb_regwrite), 32'd0);
    chk("rst_rd",  32'(bus.wb_rd), 32'd0);
    chk("rst_dat", bus.wb_data, 32'd0);
    chk("rst_cnt", 32'(bus.lq_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_ready", 32'(bus.ld_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      bus.alu_valid = tbl[i].alu_v; bus.alu_rd = tbl[i].alu_rd; bus.alu_data = tbl[i].alu_data;
      bus.ld_valid = tbl[i].ld_v; bus.ld_rd = tbl[i].ld_rd; bus.ld_data = tbl[i].ld_data;
      bus.iss_valid = tbl[i].iss_l; bus.iss_long = tbl[i].iss_l; bus.iss_rd = tbl[i].iss_rd;
      bus.q_rs1 = tbl[i].q1; bus.q_rs2 = 9;
      cyc();
      wb_exp($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_rd, tbl[i].e_data, tbl[i].e_cnt);
      chk($sformatf("vec%0d_rs1b", i), 32'(bus.rs1_busy), 32'(tbl[i].e_b1));
      chk($sformatf("vec%0d_rs2b", i), 32'(bus.rs2_busy), 32'(tbl[i].e_b2));
    end

    // Priority and full: ALU held while loads push until back-pressure
    idle();
    bus.alu_valid = 1; bus.alu_rd = 20;
    pushed = 0; guard = 0;
    while (pushed < 4 && guard < 20) begin
      bus.alu_data = 32'h100 + guard;
      bus.ld_valid = 1; bus.ld_rd = 5'(21 + pushed); bus.ld_data = 32'hA000 + pushed;
      hs = bus.ld_ready;
      cyc();
      if (hs) pushed++;
      guard++;
    end
    chk("full_pushed", 32'(pushed), 32'd4);
    chk("full_cnt",    32'(bus.lq_count), 32'd4);
    chk("full_ready",  32'(bus.ld_ready), 32'd0);
    bus.ld_rd = 25; bus.ld_data = 32'hA004;
    cyc();
    cyc();
    chk("full_hold_cnt",   32'(bus.lq_count), 32'd4);
    chk("full_hold_ready", 32'(bus.ld_ready), 32'd0);
    bus.alu_valid = 0;
    cyc();
    wb_exp("drain0", 1, 21, 32'hA000, 3);
    chk("drain0_ready", 32'(bus.ld_ready), 32'd1);
    cyc();
    wb_exp("drain1", 1, 22, 32'hA001, 3);
    bus.ld_valid = 0;
    cyc();
    wb_exp("drain2", 1, 23, 32'hA002, 2);
    cyc();
    wb_exp("drain3", 1, 24, 32'hA003, 1);
    cyc();
    wb_exp("drain4", 1, 25, 32'hA004, 0);
    cyc();
    chk("drain_idle_we", 32'(bus.wb_regwrite), 32'd0);

    // Set/clear collision on rd 3
    idle(); bus.q_rs1 = 3;
    bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 3;
    cyc();
    chk("col_set", 32'(bus.rs1_busy), 32'd1);
    idle(); bus.q_rs1 = 3;
    bus.ld_valid = 1; bus.ld_rd = 3; bus.ld_data = 32'h33;
    cyc();
    idle(); bus.q_rs1 = 3;
    cyc();
    wb_exp("col_wb", 1, 3, 32'h33, 0);
    chk("col_pre", 32'(bus.rs1_busy), 32'd1);
    bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 3;
    cyc();
    chk("col_setwins", 32'(bus.rs1_busy), 32'd1);
    idle(); bus.q_rs1 = 3;
    cyc();
    chk("col_stay", 32'(bus.rs1_busy), 32'd1);

    // Reset mid-operation with two entries held and busy[5] set
    idle(); bus.q_rs1 = 5;
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h1;
    bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 5;
    bus.ld_valid = 1; bus.ld_rd = 6; bus.ld_data = 32'h66;
    cyc();
    bus.iss_valid = 0; bus.iss_long = 0;
    bus.ld_rd = 7; bus.ld_data = 32'h77;
    cyc();
    chk("mid_cnt2",  32'(bus.lq_count), 32'd2);
    chk("mid_busy5", 32'(bus.rs1_busy), 32'd1);
    idle(); bus.q_rs1 = 5;
    reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.lq_count), 32'd0);
    chk("mid_rst_we",  32'(bus.wb_regwrite), 32'd0);
    chk("mid_rst_rd",  32'(bus.wb_rd), 32'd0);
    chk("mid_rst_dat", bus.wb_data, 32'd0);
    chk("mid_rst_b5",  32'(bus.rs1_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rel_ready", 32'(bus.ld_ready), 32'd1);
    cyc();
    chk("mid_rel_we",  32'(bus.wb_regwrite), 32'd0);
    chk("mid_rel_cnt", 32'(bus.lq_count), 32'd0);
    cyc();
    chk("mid_rel_we2", 32'(bus.wb_regwrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
